// File: rtl/snake_pkg.sv
// Shared snake-game types: FSM states, grid defaults, 5-bit cell coordinates.
// The SCAN state only exists when DRUG_SCAN_FALLBACK_EN is defined.
package snake_pkg;

    localparam int GRID_W_DEF = 32;
    localparam int GRID_H_DEF = 24;
    localparam int COORD_W    = 5;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CHECK,
`ifdef DRUG_SCAN_FALLBACK_EN
        S_SCAN,
`endif
        S_PLACED,
        S_HOLD
    } state_e;

    function automatic logic coord_eq(coord_t ax, coord_t ay, coord_t bx, coord_t by);
        return (ax == bx) && (ay == by);
    endfunction

endpackage

// File: rtl/drug_placement_ctrl_scan.sv
// Row-major cell walker used by the deterministic fallback search.
// Only built when DRUG_SCAN_FALLBACK_EN is defined.
`ifdef DRUG_SCAN_FALLBACK_EN
module drug_scan_counter
    import snake_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       step_i,
    output logic [4:0] x_o,
    output logic [4:0] y_o,
    output logic       last_o
);

    localparam coord_t XMAX = coord_t'(GRID_W - 1);
    localparam coord_t YMAX = coord_t'(GRID_H - 1);

    logic [4:0] x_q, x_d, y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (step_i) begin
            if (x_q == XMAX) begin
                x_d = '0;
                y_d = (y_q == YMAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == XMAX) && (y_q == YMAX);

endmodule
`endif

// File: rtl/drug_placement_ctrl.sv
// Drug placement: requests candidates, rejects occupied cells, holds the drug and detects eats.
// DRUG_SCAN_FALLBACK_EN adds a row-major board scan after the retry budget is spent.
module drug_placement_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF,
    parameter int MAX_RETRY = 15,
    parameter int SCORE_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               one_start,
    input  logic [4:0]         head_x,
    input  logic [4:0]         head_y,
    input  logic               head_step,
    input  logic [4:0]         cand_x,
    input  logic [4:0]         cand_y,
    input  logic               occ_hit,
    output logic               drug_valid,
    output logic [4:0]         occ_x,
    output logic [4:0]         occ_y,
    output logic [4:0]         drug_x,
    output logic [4:0]         drug_y,
    output logic               drug_present,
    output logic               eaten,
    output logic [SCORE_W-1:0] score,
    output logic               place_fail
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

    state_e               state_q, state_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [4:0]           drug_x_q, drug_x_d, drug_y_q, drug_y_d;
    logic                 present_q, present_d, eaten_q, eaten_d, fail_q, fail_d;
    logic                 x_in, y_in, cell_free;

`ifdef DRUG_SCAN_FALLBACK_EN
    logic       scan_clr, scan_step, scan_last;
    logic [4:0] scan_x, scan_y;

    drug_scan_counter #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_scan (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (scan_clr),
        .step_i (scan_step),
        .x_o    (scan_x),
        .y_o    (scan_y),
        .last_o (scan_last)
    );
`endif

    // One query port serves both the candidate check and the scan.
    always_comb begin
        occ_x = '0;
        occ_y = '0;
        case (state_q)
            S_CHECK: begin
                occ_x = cand_x;
                occ_y = cand_y;
            end
`ifdef DRUG_SCAN_FALLBACK_EN
            S_SCAN: begin
                occ_x = scan_x;
                occ_y = scan_y;
            end
`endif
            default: ;
        endcase
    end

    if (GRID_W >= 32) begin : g_x_all
        assign x_in = 1'b1;
    end else begin : g_x_lim
        assign x_in = (occ_x < coord_t'(GRID_W));
    end
    if (GRID_H >= 32) begin : g_y_all
        assign y_in = 1'b1;
    end else begin : g_y_lim
        assign y_in = (occ_y < coord_t'(GRID_H));
    end

    assign cell_free = !occ_hit && !coord_eq(occ_x, occ_y, head_x, head_y) && x_in && y_in;

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        score_d   = score_q;
        drug_x_d  = drug_x_q;
        drug_y_d  = drug_y_q;
        present_d = present_q;
        eaten_d   = 1'b0;
        fail_d    = 1'b0;
`ifdef DRUG_SCAN_FALLBACK_EN
        scan_clr  = 1'b0;
        scan_step = 1'b0;
`endif
        case (state_q)
            S_REQ: state_d = S_CHECK;
            S_CHECK: begin
                if (cell_free) begin
                    drug_x_d  = occ_x;
                    drug_y_d  = occ_y;
                    present_d = 1'b1;
                    retry_d   = '0;
                    state_d   = S_PLACED;
                end else if (retry_q < RETRY_LAST) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_REQ;
                end else begin
                    retry_d = '0;
`ifdef DRUG_SCAN_FALLBACK_EN
                    scan_clr = 1'b1;
                    state_d  = S_SCAN;
`else
                    fail_d    = 1'b1;
                    present_d = 1'b0;
                    state_d   = S_HOLD;
`endif
                end
            end
`ifdef DRUG_SCAN_FALLBACK_EN
            S_SCAN: begin
                if (cell_free) begin
                    drug_x_d  = occ_x;
                    drug_y_d  = occ_y;
                    present_d = 1'b1;
                    state_d   = S_PLACED;
                end else if (scan_last) begin
                    fail_d    = 1'b1;
                    present_d = 1'b0;
                    state_d   = S_HOLD;
                end else begin
                    scan_step = 1'b1;
                end
            end
`endif
            S_PLACED: begin
                if (head_step && coord_eq(head_x, head_y, drug_x_q, drug_y_q)) begin
                    eaten_d   = 1'b1;
                    present_d = 1'b0;
                    state_d   = S_REQ;
                    if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
                end
            end
            default: ;
        endcase
        // Restart overrides any eat or placement decision this cycle.
        if (one_start) begin
            state_d   = S_REQ;
            score_d   = '0;
            retry_d   = '0;
            present_d = 1'b0;
            eaten_d   = 1'b0;
            fail_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            retry_q   <= '0;
            score_q   <= '0;
            drug_x_q  <= '0;
            drug_y_q  <= '0;
            present_q <= 1'b0;
            eaten_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            retry_q   <= retry_d;
            score_q   <= score_d;
            drug_x_q  <= drug_x_d;
            drug_y_q  <= drug_y_d;
            present_q <= present_d;
            eaten_q   <= eaten_d;
            fail_q    <= fail_d;
        end
    end

    assign drug_valid   = (state_q == S_REQ);
    assign drug_x       = drug_x_q;
    assign drug_y       = drug_y_q;
    assign drug_present = present_q;
    assign eaten        = eaten_q;
    assign score        = score_q;
    assign place_fail   = fail_q;

endmodule

// File: tb/tb_drug_placement_ctrl.sv
// Randomized bench for drug_placement_ctrl with stub generator / body store and a placement model.
module tb_drug_placement_ctrl;

    localparam int GW = 32;
    localparam int GH = 24;
    localparam int MR = 15;
    localparam int SW = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst, one_start, head_step, occ_hit;
    logic [4:0]    head_x, head_y, cand_x, cand_y, occ_x, occ_y, drug_x, drug_y;
    logic          drug_valid, drug_present, eaten, place_fail;
    logic [SW-1:0] score;
    logic [1023:0] occ_map;
    logic [9:0]    cq[$];

    int total = 0;
    int bad = 0;
    int nreq = 0;
    int sc_exp = 0;
    int dx_exp = 0;
    int dy_exp = 0;
    bit pres_exp = 0;

    always #5 clk = ~clk;

    // Body-store stub: answers the current query from the occupancy bitmap.
    assign occ_hit = occ_map[{occ_y, occ_x}];

    drug_placement_ctrl #(.GRID_W(GW), .GRID_H(GH), .MAX_RETRY(MR), .SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .one_start(one_start),
        .head_x(head_x), .head_y(head_y), .head_step(head_step),
        .cand_x(cand_x), .cand_y(cand_y), .occ_hit(occ_hit),
        .drug_valid(drug_valid), .occ_x(occ_x), .occ_y(occ_y),
        .drug_x(drug_x), .drug_y(drug_y), .drug_present(drug_present),
        .eaten(eaten), .score(score), .place_fail(place_fail)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; generator stub hands out the next candidate on each request.
    task automatic tick();
        @(posedge clk);
        #1;
        if (drug_valid) begin
            nreq++;
            if (cq.size() > 0) {cand_y, cand_x} = cq.pop_front();
        end
    endtask

    task automatic push_cell(input int x, input int y);
        cq.push_back({5'(y), 5'(x)});
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) cq.push_back(10'($urandom_range(0, 1023)));
    endtask

    function automatic bit is_free(input int x, input int y);
        if (x >= GW || y >= GH) return 0;
        if (occ_map[y * GW + x]) return 0;
        return !(x == int'(head_x) && y == int'(head_y));
    endfunction

    // Cycles from the trigger edge to drug_present / place_fail, from the placement rules.
    task automatic predict(output int k, output bit fl, output int ex, output int ey, output int nr);
        k = 2 * MR + 3; fl = 1; ex = 0; ey = 0; nr = MR + 1;
        for (int i = 0; i <= MR; i++) begin
            int x, y;
            x = int'(cq[i][4:0]);
            y = int'(cq[i][9:5]);
            if (is_free(x, y)) begin
                k = 3 + 2 * i; fl = 0; ex = x; ey = y; nr = i + 1;
                return;
            end
        end
`ifdef DRUG_SCAN_FALLBACK_EN
        for (int j = 0; j < GW * GH; j++) begin
            if (is_free(j % GW, j / GW)) begin
                k = 2 * MR + 4 + j; fl = 0; ex = j % GW; ey = j / GW;
                return;
            end
        end
        k = 2 * MR + 3 + GW * GH;
`endif
    endtask

    task automatic finish_place(input string tag, input int t0, input int k, input bit fl,
                                input int ex, input int ey, input int nr);
        int t;
        t = t0;
        while (!drug_present && !place_fail && t < k + 50) begin
            tick();
            t++;
        end
        chk({tag, "/lat"}, t, k);
        chk({tag, "/fail"}, place_fail, fl);
        chk({tag, "/nreq"}, nreq, nr);
        if (!fl) begin
            chk({tag, "/x"}, drug_x, ex);
            chk({tag, "/y"}, drug_y, ey);
            dx_exp = ex;
            dy_exp = ey;
        end
        pres_exp = !fl;
        tick();
        chk({tag, "/fail_pulse"}, place_fail, 0);
        chk({tag, "/present"}, drug_present, !fl);
    endtask

    // Trigger a placement by restart (by_eat=0) or by stepping the head onto the drug.
    task automatic attempt(input string tag, input bit by_eat);
        int k, ex, ey, nr, t0;
        bit fl;
        if (by_eat) begin
            head_x = 5'(dx_exp);
            head_y = 5'(dy_exp);
        end
        predict(k, fl, ex, ey, nr);
        nreq = 0;
        if (by_eat) begin
            head_step = 1'b1;
            tick();
            head_step = 1'b0;
            if (sc_exp < SMAX) sc_exp++;
            chk({tag, "/eaten"}, eaten, 1);
        end else begin
            one_start = 1'b1;
            tick();
            one_start = 1'b0;
            sc_exp = 0;
        end
        chk({tag, "/req"}, drug_valid, 1);
        chk({tag, "/score"}, score, sc_exp);
        chk({tag, "/cleared"}, drug_present, 0);
        t0 = 1;
        if (by_eat) begin
            tick();
            t0 = 2;
            chk({tag, "/eat_pulse"}, eaten, 0);
        end
        finish_place(tag, t0, k, fl, ex, ey, nr);
    endtask

    initial begin
        int k, ex, ey, nr, n0;
        bit fl;
        rst = 1'b0; one_start = 1'b0; head_step = 1'b0;
        head_x = '0; head_y = '0; cand_x = '0; cand_y = '0; occ_map = '0;
        #2 rst = 1'b1;
        #2;
        chk("rst/valid", drug_valid, 0);
        chk("rst/present", drug_present, 0);
        chk("rst/eaten", eaten, 0);
        chk("rst/fail", place_fail, 0);
        chk("rst/score", score, 0);
        chk("rst/dx", drug_x, 0);
        chk("rst/dy", drug_y, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First candidate free.
        push_cell(8, 16); fill_rand(15);
        attempt("first", 0);

        // Head step that misses the drug.
        head_x = 5'((dx_exp + 1) % GW); head_y = 5'(dy_exp);
        head_step = 1'b1; tick(); head_step = 1'b0;
        chk("miss/eaten", eaten, 0);
        chk("miss/present", drug_present, 1);

        // Eat, then three occupied candidates before a free one.
        cq.delete();
        occ_map[1 * GW + 1] = 1'b1; occ_map[2 * GW + 2] = 1'b1; occ_map[4 * GW + 4] = 1'b1;
        push_cell(1, 1); push_cell(2, 2); push_cell(4, 4); push_cell(3, 5); fill_rand(12);
        attempt("retry3", 1);

        // Board full: retries (and scan, if built) exhausted.
        cq.delete(); occ_map = '1; fill_rand(16);
        attempt("full", 0);
        n0 = nreq;
        repeat (4) tick();
        chk("hold/no_req", nreq, n0);
        chk("hold/present", drug_present, 0);
        cq.delete(); occ_map = '0; head_x = 5'd0; head_y = 5'd0;
        push_cell(9, 9); fill_rand(15);
        attempt("recover", 0);

`ifdef DRUG_SCAN_FALLBACK_EN
        cq.delete(); occ_map = '1; occ_map[1 * GW + 2] = 1'b0; fill_rand(16);
        attempt("scan21", 0);
        occ_map = '0;
`endif

        // Restart while a free candidate sits in CHECK.
        cq.delete(); push_cell(6, 6); push_cell(7, 7); fill_rand(15);
        one_start = 1'b1; tick(); one_start = 1'b0;
        tick();
        predict(k, fl, ex, ey, nr);
        nreq = 0;
        one_start = 1'b1; tick(); one_start = 1'b0;
        sc_exp = 0;
        chk("midchk/req", drug_valid, 1);
        chk("midchk/present", drug_present, 0);
        finish_place("midchk", 1, k, fl, ex, ey, nr);

        // Score saturation.
        for (int i = 0; i < 5; i++) begin
            cq.delete(); push_cell(i + 10, i + 2); fill_rand(15);
            attempt("sat", 1);
        end

        // Random placements against random boards.
        for (int it = 0; it < 30; it++) begin
            for (int w = 0; w < 32; w++) begin
                if ($urandom_range(0, 9) == 0) occ_map[w * 32 +: 32] = ~($urandom & $urandom);
                else occ_map[w * 32 +: 32] = $urandom & $urandom;
            end
            cq.delete(); fill_rand(16);
            if (pres_exp && $urandom_range(0, 3) != 0) begin
                attempt("rand_eat", 1);
            end else begin
                head_x = 5'($urandom_range(0, GW - 1));
                head_y = 5'($urandom_range(0, GH - 1));
                attempt("rand_start", 0);
            end
        end

        // Reset in the middle of a check aborts to the reset state.
        occ_map = '0; cq.delete(); push_cell(12, 13); fill_rand(15);
        one_start = 1'b1; tick(); one_start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rstchk/valid", drug_valid, 0);
        chk("rstchk/present", drug_present, 0);
        chk("rstchk/eaten", eaten, 0);
        chk("rstchk/fail", place_fail, 0);
        chk("rstchk/score", score, 0);
        chk("rstchk/dx", drug_x, 0);
        chk("rstchk/dy", drug_y, 0);
        chk("rstchk/occ", occ_x, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle/valid", drug_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
